// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor; WIDTH split into STAGES slices of 4-bit lookahead groups.
// Latency: STAGES cycles from the cycle operands are presented to out_valid; one result per cycle.
// Backpressure: global advance (!out_valid | out_ready) gates every stage; in_ready mirrors it, nothing collapses.
module cla_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW  = WIDTH / STAGES;  // slice width
  localparam int NGS = SW / 4;          // lookahead groups per slice

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_b_eff  = b ^ {WIDTH{sub}};

  // One slice: per-group P/G, second-level lookahead for group carries, then
  // in-group lookahead carries. Returns {carry out, sum bits}.
  function automatic logic [SW:0] slice_add(input logic [SW-1:0] x,
                                            input logic [SW-1:0] y,
                                            input logic          ci);
    logic [SW-1:0]  p;
    logic [SW-1:0]  g;
    logic [SW-1:0]  s;
    logic [NGS-1:0] gp;
    logic [NGS-1:0] gg;
    logic [NGS:0]   gc;
    logic [3:0]     c;
    logic           t;
    p = x ^ y;
    g = x & y;
    s = '0;
    for (int j = 0; j < NGS; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    // Group carries as flat sum-of-products over group P/G, no inter-group ripple.
    for (int j = 0; j <= NGS; j++) begin
      t = ci;
      for (int q = 0; q < j; q++) t = t & gp[q];
      gc[j] = t;
      for (int m = 0; m < j; m++) begin
        t = gg[m];
        for (int q = m + 1; q < j; q++) t = t & gp[q];
        gc[j] = gc[j] | t;
      end
    end
    for (int j = 0; j < NGS; j++) begin
      c[0] = gc[j];
      c[1] = g[4*j] | (p[4*j] & gc[j]);
      c[2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
           | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
      s[4*j +: 4] = p[4*j +: 4] ^ c;
    end
    return {gc[NGS], s};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Operand bits not yet added when entering stage k.
    localparam int REM = WIDTH - k * SW;

    logic [REM-1:0]        w_a;
    logic [REM-1:0]        w_b;
    logic                  w_c;
    logic                  w_v;
    logic [SW:0]           w_res;
    logic [(k+1)*SW-1:0]   w_s_nxt;
    logic                  r_v;
    logic                  r_c;
    logic [(k+1)*SW-1:0]   r_s;

    if (k == 0) begin : g_src
      assign w_a     = a;
      assign w_b     = w_b_eff;
      assign w_c     = cin;
      assign w_v     = in_valid;
      assign w_s_nxt = w_res[SW-1:0];
    end else begin : g_src
      assign w_a     = g_stg[k-1].g_op.r_a;
      assign w_b     = g_stg[k-1].g_op.r_b;
      assign w_c     = g_stg[k-1].r_c;
      assign w_v     = g_stg[k-1].r_v;
      assign w_s_nxt = {w_res[SW-1:0], g_stg[k-1].r_s};
    end

    assign w_res = slice_add(w_a[SW-1:0], w_b[SW-1:0], w_c);

    // Stage valid, slice carry-out and the completed lower sum bits.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_v;
        r_c <= w_res[SW];
        r_s <= w_s_nxt;
      end
    end

    if (k < STAGES - 1) begin : g_op
      logic [REM-SW-1:0] r_a;
      logic [REM-SW-1:0] r_b;
      // Upper operand bits ride along with the carry to the next slice.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a[REM-1:SW];
          r_b <= w_b[REM-1:SW];
        end
      end
    end else begin : g_last
      logic r_ovf;
      // Carry into the MSB is recovered as sum^a^b at that bit; overflow is it XOR carry out.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= w_res[SW] ^ (w_res[SW-1] ^ w_a[SW-1] ^ w_b[SW-1]);
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].r_v;
  assign sum       = g_stg[STAGES-1].r_s;
  assign cout      = g_stg[STAGES-1].r_c;
  assign ovf       = g_stg[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder (16-bit, 2 stages) plus a random sweep over four other configurations.
// Inputs change 1 time unit after the rising edge; outputs and handshakes are sampled on the falling edge.
// Sweep instances share random operands; each keeps its own expected-result FIFO in acceptance order.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  cla_pipe_adder #(.WIDTH(16), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  localparam int CW[4] = '{8, 16, 32, 32};
  localparam int CS[4] = '{1, 4, 2, 8};

  logic        sw_iv;
  logic        sw_cin;
  logic        sw_sub;
  logic [31:0] sw_a;
  logic [31:0] sw_b;
  logic [3:0]  sw_ordy;
  logic [3:0]  sw_ir;
  logic [3:0]  sw_ov;
  logic [3:0]  sw_co;
  logic [3:0]  sw_of;
  logic [31:0] sw_sum[4];
  logic [33:0] sw_q[4][512];
  int          sw_wr[4] = '{0, 0, 0, 0};
  int          sw_rd[4] = '{0, 0, 0, 0};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    localparam int W = CW[gi];
    logic [W-1:0] w_sum;
    cla_pipe_adder #(.WIDTH(W), .STAGES(CS[gi])) u_dut (
      .clk(clk), .rst(rst), .in_valid(sw_iv), .in_ready(sw_ir[gi]),
      .a(sw_a[W-1:0]), .b(sw_b[W-1:0]), .cin(sw_cin), .sub(sw_sub),
      .out_valid(sw_ov[gi]), .out_ready(sw_ordy[gi]),
      .sum(w_sum), .cout(sw_co[gi]), .ovf(sw_of[gi])
    );
    assign sw_sum[gi] = 32'(w_sum);
  end

  // Reference: plain wide addition; returns {cout, ovf, sum} for width w.
  function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic sb);
    logic [31:0] mask;
    logic [31:0] xm;
    logic [31:0] ye;
    logic [31:0] s;
    logic [32:0] full;
    logic        co;
    logic        of;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    xm   = x & mask;
    ye   = (y ^ {32{sb}}) & mask;
    full = {1'b0, xm} + {1'b0, ye} + {32'h0, ci};
    s    = full[31:0] & mask;
    co   = full[w];
    of   = (xm[w-1] == ye[w-1]) && (s[w-1] != xm[w-1]);
    return {co, of, s};
  endfunction

  function automatic logic [39:0] obs16();
    return 40'({out_valid, cout, ovf, sum});
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed back-to-back vectors: {a, b, cin, sub} and expected {cout, ovf, sum}.
  localparam logic [15:0] VA[5]   = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
  localparam logic [15:0] VB[5]   = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
  localparam logic        VCI[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic        VSUB[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [17:0] DEXP[5] = '{{2'b00, 16'h0100}, {2'b10, 16'h0000}, {2'b01, 16'h8000},
                                      {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF}};

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nin;
    int nout;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    sw_iv = 1'b0; sw_cin = 1'b0; sw_sub = 1'b0; sw_a = '0; sw_b = '0; sw_ordy = 4'hF;

    // Reset state after two reset edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", obs16(), 40'h0);
    chk("rst_in_ready", 40'(in_ready), 40'h1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency and back-to-back stream: vector i driven in iteration i, seen in iteration i+2
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        in_valid = 1'b1; a = VA[i]; b = VB[i]; cin = VCI[i]; sub = VSUB[i];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 2) chk($sformatf("lat_early%0d", i), 40'(out_valid), 40'h0);
      else       chk($sformatf("vec%0d", i - 2), obs16(), 40'({1'b1, DEXP[i-2]}));
      @(posedge clk); #1;
    end
    cin = 1'b0; sub = 1'b0;

    // Backpressure: six sets a=i, b=0x100*i; out_ready low in cycles 4..6
    nin = 0; nout = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      in_valid  = (nin < 6);
      a = 16'(nin + 1);
      b = 16'((nin + 1) * 256);
      @(negedge clk);
      chk($sformatf("bp_in_ready_c%0d", c), 40'(in_ready), 40'(!(c >= 4 && c <= 6)));
      if (c >= 4 && c <= 6)
        chk($sformatf("bp_hold_c%0d", c), obs16(), 40'({3'b100, 16'(257 * (nout + 1))}));
      if (out_valid && out_ready) begin
        chk($sformatf("bp_res%0d", nout), obs16(), 40'({3'b100, 16'(257 * (nout + 1))}));
        nout++;
      end
      if (in_valid && in_ready) nin++;
      @(posedge clk); #1;
    end
    chk("bp_count", 40'(nout), 40'd6);
    chk("bp_drained", 40'(out_valid), 40'h0);
    in_valid = 1'b0; out_ready = 1'b1;

    // Reset mid-flight: two sets in, reset lands on the edge the first would reach the output
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
    @(negedge clk);
    chk("rmf_c0", 40'(out_valid), 40'h0);
    @(posedge clk); #1;
    a = 16'h3333; b = 16'h4444; rst = 1'b1;
    @(negedge clk);
    chk("rmf_c1", 40'(out_valid), 40'h0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rmf_cleared", obs16(), 40'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("rmf_none%0d", c), 40'(out_valid), 40'h0);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'h1234; b = 16'h1111;
    @(negedge clk);
    chk("rmf_new_c0", 40'(out_valid), 40'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rmf_new_c1", 40'(out_valid), 40'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rmf_new_res", obs16(), 40'({3'b100, 16'h2345}));
    @(posedge clk); #1;

    // Parameter sweep: all-ones corners first, then random operands and out_ready, then drain
    for (int c = 0; c < 420; c++) begin
      if (c < 8) begin
        sw_iv = 1'b1; sw_a = 32'hFFFF_FFFF; sw_b = 32'hFFFF_FFFF; sw_cin = 1'b1;
        sw_sub = (c >= 4); sw_ordy = 4'hF;
      end else if (c < 400) begin
        sw_iv = ($urandom_range(0, 3) != 0);
        sw_a = $urandom; sw_b = $urandom;
        sw_cin = 1'($urandom_range(0, 1)); sw_sub = 1'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++) sw_ordy[i] = ($urandom_range(0, 3) != 0);
      end else begin
        sw_iv = 1'b0; sw_ordy = 4'hF;
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (sw_ov[i] && sw_ordy[i]) begin
          if (sw_rd[i] < sw_wr[i]) begin
            chk($sformatf("sweep%0d_res%0d", i, sw_rd[i]),
                40'({sw_co[i], sw_of[i], sw_sum[i]}), 40'(sw_q[i][sw_rd[i]]));
            sw_rd[i]++;
          end else begin
            chk($sformatf("sweep%0d_extra", i), 40'(sw_ov[i]), 40'h0);
          end
        end
        if (sw_iv && sw_ir[i]) begin
          sw_q[i][sw_wr[i]] = model(CW[i], sw_a, sw_b, sw_cin, sw_sub);
          sw_wr[i]++;
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("sweep%0d_all_out", i), 40'(sw_rd[i]), 40'(sw_wr[i]));
    chk("sweep_idle", 40'(sw_ov), 40'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
